controlador_estados_param: RTL and testbench
============================================

# controlador_estados_param

Parametrised successor to the Tamagotchi state controller. It runs the pet's mood/activity state machine from two buttons and a configurable bank of need counters (fome, felicidade, sono, …). New over the previous generation: explicit synchronous reset, automatic return to IDLE after a bounded activity, per-stat low-level alerts, recorded cause of death, and revival from MORTO by holding both buttons. It sits between the button debouncers / stat decay blocks and the display/sprite selector.

## Interface
- STAT_W, 8: width of each stat.
- N_STATS, 3: number of stats; index 0 = fome, 1 = felicidade, 2 = sono, higher = extra needs.
- TICK_W, 22: decision tick period is 2^TICK_W clock cycles.
- ACT_TICKS, 8: maximum ticks spent in COMENDO/DORMINDO/DANDO_AULA before auto-return to IDLE; 0 disables auto-return.
- LOW_THR, 16: alert threshold; a stat strictly below it raises its alert.
- REVIVE_TICKS, 4: consecutive ticks with both buttons pressed needed to revive; minimum 1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- b1  in  1  button 1, already debounced, level.
- b2  in  1  button 2, already debounced, level.
- stats  in  N_STATS*STAT_W  packed stats; stat i = stats[i*STAT_W +: STAT_W].
- estado  out  5  one-hot state: INTRO 00000, IDLE 00001, DORMINDO 00010, COMENDO 00100, DANDO_AULA 01000, MORTO 10000.
- tick  out  1  one-cycle pulse, high in the cycle a new decision is visible on estado.
- alerta  out  N_STATS  bit i = stat i < LOW_THR (forced 0 in MORTO).
- morto_causa  out  N_STATS  mask of stats equal to 0 at the moment of death; held until revival.

## Operation
- Reset (rst_n low at posedge): estado = INTRO; tick counter, b1/b2 latches, act_cnt, revive_cnt, tick, alerta, morto_causa all 0. Reset beats every other event in the same cycle.
- Tick counter: TICK_W bits, free-running, wraps. A decision edge is the posedge where counter == 2^TICK_W−1.
- Button latches: set on any cycle with the button high; cleared on the decision edge. Effective press at a decision edge = latch OR current input (a press in the decision cycle counts and is consumed).
- Decisions at the decision edge, in priority order:
  - Death: state ≠ MORTO and any stat == 0 → MORTO; morto_causa ← zero-mask; revive_cnt ← 0. Buttons are ignored.
  - MORTO: both pressed → revive_cnt+1, saturating at REVIVE_TICKS; otherwise revive_cnt ← 0. When the incremented value reaches REVIVE_TICKS and all stats ≠ 0 → INTRO, morto_causa ← 0, revive_cnt ← 0. Otherwise stay MORTO.
  - INTRO: any press → IDLE; else stay.
  - IDLE: b1 only → COMENDO; b2 only → DORMINDO; both → DANDO_AULA; none → IDLE. act_cnt ← 0.
  - Activity states: any press → IDLE, act_cnt ← 0. Else, if ACT_TICKS ≠ 0 and act_cnt == ACT_TICKS−1 → IDLE, act_cnt ← 0; else act_cnt+1.
- alerta: registered every cycle from the current stats and state (not only on ticks).

## Timing
- estado changes only on decision edges. It is visible one cycle after the edge, together with the tick pulse.
- Stats are sampled for death/revival only at the decision edge. A zero pulse between edges is not seen.
- alerta latency: one cycle from a stats/estado change.
- Maximum activity duration: ACT_TICKS decision edges after entry.
- Revival latency: REVIVE_TICKS consecutive decision edges with both buttons pressed. A missed window restarts the count.
- First decision edge after reset release: cycle 2^TICK_W−1.

## Test plan
All scenarios use TICK_W=3 (edge every 8 cycles), ACT_TICKS=4, REVIVE_TICKS=2, LOW_THR=16, all stats 100 unless stated.
- Reset release, no buttons for 40 cycles → estado stays 00000. Then a one-cycle b1 pulse at cycle 2 of a window → estado 00001 and tick=1 right after that window's edge.
- IDLE, b1 and b2 pressed in different cycles of one window → DANDO_AULA (01000). In the next IDLE window, b2 only → DORMINDO (00010). With no further presses → IDLE after exactly 4 edges.
- COMENDO, sono set to 0 and b1 held → MORTO (10000) at the next edge, morto_causa = 3'b100. Remains MORTO with single-button presses.
- MORTO with stats restored to 50, both held for 2 windows → INTRO at the second edge, morto_causa = 0. Variant: both for 1 window, then none, then both for 1 window → still MORTO. Variant: stats contain a 0 → never revives.
- felicidade = 15 → alerta = 3'b010 one cycle later. Set it to 16 → alerta = 0. In MORTO with fome = 0 → alerta = 0.
- rst_n low in the same cycle as a decision edge during DORMINDO with act_cnt = 2 → next cycle estado = INTRO and all counters and outputs 0. The next edge occurs 7 cycles after rst_n rises.

Source files
------------

// File: rtl/controlador_estados_param.sv
// Pet mood/activity controller: one-hot state machine advanced on a periodic decision
// tick, driven by two buttons and a bank of need counters, with alerts and revival.
module controlador_estados_param #(
    parameter int STAT_W       = 8,
    parameter int N_STATS      = 3,
    parameter int TICK_W       = 22,
    parameter int ACT_TICKS    = 8,
    parameter int LOW_THR      = 16,
    parameter int REVIVE_TICKS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        b1,
    input  logic                        b2,
    input  logic [N_STATS*STAT_W-1:0]   stats,
    output logic [4:0]                  estado,
    output logic                        tick,
    output logic [N_STATS-1:0]          alerta,
    output logic [N_STATS-1:0]          morto_causa
);

    typedef enum logic [4:0] {
        INTRO      = 5'b00000,
        IDLE       = 5'b00001,
        DORMINDO   = 5'b00010,
        COMENDO    = 5'b00100,
        DANDO_AULA = 5'b01000,
        MORTO      = 5'b10000
    } estado_t;

    localparam int ACT_W = (ACT_TICKS > 1) ? $clog2(ACT_TICKS) : 1;
    localparam int REV_W = $clog2(REVIVE_TICKS + 1);
    localparam logic [ACT_W-1:0] ACT_LAST = (ACT_TICKS > 0) ? ACT_W'(ACT_TICKS - 1) : '0;
    localparam logic [REV_W-1:0] REV_MAX  = REV_W'(REVIVE_TICKS);

    estado_t             state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt;
    logic                b1_lat, b2_lat;
    logic [ACT_W-1:0]    act_cnt_q, act_cnt_d;
    logic [REV_W-1:0]    rev_cnt_q, rev_cnt_d, rev_inc;
    logic [N_STATS-1:0]  causa_d, zero_mask, low_mask;
    logic                decision, p1, p2;

    assign decision = &tick_cnt;
    // A press counts if it was latched earlier in the window or is present right now.
    assign p1       = b1_lat | b1;
    assign p2       = b2_lat | b2;
    assign rev_inc  = (rev_cnt_q == REV_MAX) ? rev_cnt_q : rev_cnt_q + 1'b1;
    assign estado   = state_q;

    always_comb begin
        zero_mask = '0;
        low_mask  = '0;
        for (int i = 0; i < N_STATS; i++) begin
            zero_mask[i] = (stats[i*STAT_W +: STAT_W] == '0);
            low_mask[i]  = (stats[i*STAT_W +: STAT_W] < STAT_W'(LOW_THR));
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        act_cnt_d = act_cnt_q;
        rev_cnt_d = rev_cnt_q;
        causa_d   = morto_causa;
        if (state_q != MORTO && |zero_mask) begin
            state_d   = MORTO;
            causa_d   = zero_mask;
            rev_cnt_d = '0;
        end else begin
            case (state_q)
                MORTO: begin
                    if (p1 && p2) begin
                        if (rev_inc == REV_MAX && !(|zero_mask)) begin
                            state_d   = INTRO;
                            causa_d   = '0;
                            rev_cnt_d = '0;
                        end else begin
                            rev_cnt_d = rev_inc;
                        end
                    end else begin
                        rev_cnt_d = '0;
                    end
                end
                INTRO: begin
                    if (p1 || p2) state_d = IDLE;
                end
                IDLE: begin
                    act_cnt_d = '0;
                    case ({p1, p2})
                        2'b10:   state_d = COMENDO;
                        2'b01:   state_d = DORMINDO;
                        2'b11:   state_d = DANDO_AULA;
                        default: state_d = IDLE;
                    endcase
                end
                DORMINDO, COMENDO, DANDO_AULA: begin
                    if (p1 || p2) begin
                        state_d   = IDLE;
                        act_cnt_d = '0;
                    end else if (ACT_TICKS != 0 && act_cnt_q == ACT_LAST) begin
                        state_d   = IDLE;
                        act_cnt_d = '0;
                    end else begin
                        act_cnt_d = act_cnt_q + 1'b1;
                    end
                end
                default: state_d = INTRO;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INTRO;
            tick_cnt    <= '0;
            b1_lat      <= 1'b0;
            b2_lat      <= 1'b0;
            act_cnt_q   <= '0;
            rev_cnt_q   <= '0;
            tick        <= 1'b0;
            alerta      <= '0;
            morto_causa <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick     <= decision;
            alerta   <= (state_q == MORTO) ? '0 : low_mask;
            if (decision) begin
                state_q     <= state_d;
                act_cnt_q   <= act_cnt_d;
                rev_cnt_q   <= rev_cnt_d;
                morto_causa <= causa_d;
                b1_lat      <= 1'b0;
                b2_lat      <= 1'b0;
            end else begin
                if (b1) b1_lat <= 1'b1;
                if (b2) b2_lat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_controlador_estados_param.sv
// Scoreboard bench for controlador_estados_param: each decision window queues its
// expected state/cause, and a tick-driven monitor pops and compares.
module tb_controlador_estados_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b1, b2;
    logic [23:0] stats;
    logic [4:0]  estado;
    logic        tick;
    logic [2:0]  alerta;
    logic [2:0]  morto_causa;

    typedef struct {
        logic [4:0] estado;
        logic [2:0] causa;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [4:0] S_INTRO = 5'b00000, S_IDLE = 5'b00001, S_DORM = 5'b00010,
                           S_COME  = 5'b00100, S_AULA = 5'b01000, S_MORTO = 5'b10000;

    controlador_estados_param #(
        .STAT_W(8), .N_STATS(3), .TICK_W(3), .ACT_TICKS(4), .LOW_THR(16), .REVIVE_TICKS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .stats(stats),
        .estado(estado), .tick(tick), .alerta(alerta), .morto_causa(morto_causa)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every tick pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tick === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_tick", 32'(estado), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("estado", 32'(estado), 32'(e.estado));
                check("morto_causa", 32'(morto_causa), 32'(e.causa));
            end
        end
    end

    // One 8-cycle decision window; masks give per-cycle button levels, bit 7 = decision cycle.
    task automatic win(input logic [7:0] m1, input logic [7:0] m2,
                       input logic [7:0] fome, input logic [7:0] fel, input logic [7:0] sono,
                       input logic [4:0] est, input logic [2:0] causa, input logic [2:0] al,
                       input bit rst_edge);
        int   early;
        exp_t e;
        stats = {sono, fel, fome};
        if (!rst_edge) begin
            e.estado = est;
            e.causa  = causa;
            sb.push_back(e);
        end
        early = 0;
        for (int i = 0; i < 8; i++) begin
            b1 = m1[i];
            b2 = m2[i];
            if (rst_edge && i == 7) rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (i == 0) check("alerta", 32'(alerta), 32'(al));
            if (i < 7 && tick) early++;
        end
        check("tick_early", early, 0);
        b1 = 1'b0;
        b2 = 1'b0;
        if (rst_edge) begin
            check("rst_estado", 32'(estado), 32'(S_INTRO));
            check("rst_tick", 32'(tick), 0);
            check("rst_alerta", 32'(alerta), 0);
            check("rst_causa", 32'(morto_causa), 0);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        b1    = 1'b0;
        b2    = 1'b0;
        stats = {8'd100, 8'd5, 8'd100};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_estado", 32'(estado), 32'(S_INTRO));
        check("reset_tick", 32'(tick), 0);
        check("reset_alerta", 32'(alerta), 0);
        check("reset_causa", 32'(morto_causa), 0);
        rst_n = 1'b1;

        //   b1 mask   b2 mask   fome    fel     sono    estado   causa   alerta  rst
        for (int w = 0; w < 5; w++)
            win(8'h00, 8'h00, 8'd100, 8'd100, 8'd100, S_INTRO, 3'b000, 3'b000, 0);
        win(8'h04, 8'h00, 8'd100, 8'd100, 8'd100, S_IDLE,  3'b000, 3'b000, 0);
        win(8'h02, 8'h20, 8'd100, 8'd100, 8'd100, S_AULA,  3'b000, 3'b000, 0);
        win(8'h01, 8'h00, 8'd100, 8'd100, 8'd100, S_IDLE,  3'b000, 3'b000, 0);
        win(8'h00, 8'h08, 8'd100, 8'd100, 8'd100, S_DORM,  3'b000, 3'b000, 0);
        for (int w = 0; w < 3; w++)
            win(8'h00, 8'h00, 8'd100, 8'd100, 8'd100, S_DORM, 3'b000, 3'b000, 0);
        win(8'h00, 8'h00, 8'd100, 8'd100, 8'd100, S_IDLE,  3'b000, 3'b000, 0);
        win(8'h80, 8'h00, 8'd100, 8'd100, 8'd100, S_COME,  3'b000, 3'b000, 0);
        // Death while a button is held: cause records sono.
        win(8'hFF, 8'h00, 8'd100, 8'd100, 8'd0,   S_MORTO, 3'b100, 3'b100, 0);
        win(8'hFF, 8'h00, 8'd100, 8'd100, 8'd0,   S_MORTO, 3'b100, 3'b000, 0);
        win(8'h00, 8'hFF, 8'd50,  8'd50,  8'd50,  S_MORTO, 3'b100, 3'b000, 0);
        // Broken revival streaks.
        win(8'hFF, 8'hFF, 8'd50,  8'd50,  8'd50,  S_MORTO, 3'b100, 3'b000, 0);
        win(8'h00, 8'h00, 8'd50,  8'd50,  8'd50,  S_MORTO, 3'b100, 3'b000, 0);
        win(8'hFF, 8'hFF, 8'd50,  8'd50,  8'd50,  S_MORTO, 3'b100, 3'b000, 0);
        win(8'h00, 8'h00, 8'd50,  8'd50,  8'd50,  S_MORTO, 3'b100, 3'b000, 0);
        // A zero stat blocks revival; alerta stays 0 in MORTO.
        for (int w = 0; w < 3; w++)
            win(8'hFF, 8'hFF, 8'd0, 8'd50, 8'd50, S_MORTO, 3'b100, 3'b000, 0);
        win(8'h00, 8'h00, 8'd50,  8'd50,  8'd50,  S_MORTO, 3'b100, 3'b000, 0);
        win(8'hFF, 8'hFF, 8'd50,  8'd50,  8'd50,  S_MORTO, 3'b100, 3'b000, 0);
        win(8'hFF, 8'hFF, 8'd50,  8'd50,  8'd50,  S_INTRO, 3'b000, 3'b000, 0);
        // Alert threshold boundary on felicidade.
        win(8'h00, 8'h01, 8'd100, 8'd15,  8'd100, S_IDLE,  3'b000, 3'b010, 0);
        win(8'h00, 8'h04, 8'd100, 8'd16,  8'd100, S_DORM,  3'b000, 3'b000, 0);
        win(8'h00, 8'h00, 8'd100, 8'd100, 8'd100, S_DORM,  3'b000, 3'b000, 0);
        win(8'h00, 8'h00, 8'd100, 8'd100, 8'd100, S_DORM,  3'b000, 3'b000, 0);
        // Reset on the decision edge with act_cnt = 2 and a latched b1 press.
        win(8'h02, 8'h00, 8'd100, 8'd10,  8'd100, S_INTRO, 3'b000, 3'b010, 1);
        win(8'h00, 8'h00, 8'd100, 8'd100, 8'd100, S_INTRO, 3'b000, 3'b000, 0);
        win(8'h08, 8'h08, 8'd100, 8'd100, 8'd100, S_IDLE,  3'b000, 3'b000, 0);
        win(8'h20, 8'h40, 8'd100, 8'd100, 8'd100, S_AULA,  3'b000, 3'b000, 0);
        win(8'h00, 8'h00, 8'd0,   8'd0,   8'd100, S_MORTO, 3'b011, 3'b011, 0);
        win(8'h00, 8'h00, 8'd0,   8'd0,   8'd100, S_MORTO, 3'b011, 3'b000, 0);

        @(posedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
